// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load_op bit
// indices and the packed layouts of the exe->mem, mem->wb and forwarding buses.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 158;
  localparam int MS_TO_WS_BUS_WD = 152;
  localparam int MS_FWD_BUS_WD   = 39;

  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;

  // Field order is MSB first, matching the concatenations used by neighbours.
  typedef struct packed {
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [4:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        csr_re;
    logic        fwd_valid;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_fwd_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and data buses around the memory stage; master is the stage itself,
// slave is the surrounding pipeline (exe, wb, decode, data SRAM, commit).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus;
  logic [31:0]                data_sram_rdata;
  logic                       ms_ex;
  logic                       ms_flush_pipe;

  modport master (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata, ms_flush_pipe,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
  );

  modport slave (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata, ms_flush_pipe,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_ex
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the byte/half lane out of a loaded word and sign- or zero-extends it
// according to the one-hot load_op.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  vaddr,
  input  logic [4:0]  load_op,
  output logic [31:0] load_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half lane follows vaddr[1] only; misaligned halves are trapped upstream.
  always_comb begin
    byte_sel = mem_word[{vaddr, 3'b000} +: 8];
    half_sel = vaddr[1] ? mem_word[31:16] : mem_word[15:0];
    load_result = mem_word;
    if (load_op[LD_B]) begin
      load_result = {{24{byte_sel[7]}}, byte_sel};
    end else if (load_op[LD_H]) begin
      load_result = {{16{half_sel[15]}}, half_sel};
    end else if (load_op[LD_BU]) begin
      load_result = {24'd0, byte_sel};
    end else if (load_op[LD_HU]) begin
      load_result = {16'd0, half_sel};
    end else if (load_op[LD_W]) begin
      load_result = mem_word;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the exe bus, merges the SRAM response
// (held across wb stalls) into the writeback value, and drives forwarding.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.master bus
);

  es_to_ms_bus_t ms_bus;
  ms_to_ws_bus_t ws_out;
  ms_fwd_bus_t   fwd_out;

  logic        ms_valid;
  logic        ms_allowin;
  logic        accept;
  logic        first_cycle;
  logic        hold_valid;
  logic [31:0] rdata_hold;
  logic [31:0] mem_word;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign ms_allowin = !ms_valid || bus.ws_allowin;
  assign accept     = bus.es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (bus.ms_flush_pipe) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= bus.es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_bus      <= '0;
      first_cycle <= 1'b0;
    end else begin
      first_cycle <= accept;
      if (accept) begin
        ms_bus <= es_to_ms_bus_t'(bus.es_to_ms_bus);
      end
    end
  end

  // The SRAM answers only in the first cycle; keep that word if wb stalls us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      rdata_hold <= '0;
    end else if (bus.ms_flush_pipe || accept) begin
      hold_valid <= 1'b0;
    end else if (ms_valid && first_cycle && ms_bus.res_from_mem && !bus.ws_allowin) begin
      hold_valid <= 1'b1;
      rdata_hold <= bus.data_sram_rdata;
    end else if (ms_valid && bus.ws_allowin) begin
      hold_valid <= 1'b0;
    end
  end

  assign mem_word = hold_valid ? rdata_hold : bus.data_sram_rdata;

  mem_stage_load_align u_load_align (
    .mem_word    (mem_word),
    .vaddr       (ms_bus.result[1:0]),
    .load_op     (ms_bus.load_op),
    .load_result (load_result)
  );

  assign final_result = ms_bus.res_from_mem ? load_result : ms_bus.result;

  always_comb begin
    ws_out              = '0;
    ws_out.csr_wvalue   = ms_bus.csr_wvalue;
    ws_out.ertn         = ms_bus.ertn;
    ws_out.syscall      = ms_bus.syscall;
    ws_out.csr_re       = ms_bus.csr_re;
    ws_out.csr_we       = ms_bus.csr_we;
    ws_out.csr_num      = ms_bus.csr_num;
    ws_out.csr_wmask    = ms_bus.csr_wmask;
    ws_out.gr_we        = ms_bus.gr_we;
    ws_out.dest         = ms_bus.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = ms_bus.pc;

    fwd_out              = '0;
    fwd_out.csr_re       = ms_bus.csr_re;
    fwd_out.fwd_valid    = ms_valid && ms_bus.gr_we && !bus.ms_flush_pipe;
    fwd_out.dest         = ms_bus.dest;
    fwd_out.final_result = final_result;
  end

  assign bus.ms_allowin     = ms_allowin;
  assign bus.ms_to_ws_valid = ms_valid && !bus.ms_flush_pipe;
  assign bus.ms_to_ws_bus   = ws_out;
  assign bus.ms_fwd_bus     = fwd_out;
  assign bus.ms_ex          = ms_valid && (ms_bus.syscall || ms_bus.ertn);

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage, checked against a
// per-instruction model of what wb and decode should see each cycle.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [4:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  int total = 0;
  int bad   = 0;

  bit          m_valid = 1'b0;
  bit          m_first = 1'b0;
  logic [31:0] m_word  = '0;
  ins_t        m_ins   = '0;

  logic [31:0] obs_final;
  logic [38:0] obs_fwd;
  logic        obs_ex;

  task automatic check_output(input string tag, input logic [151:0] actual, input logic [151:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Expected load value computed with shifts/masks and two's-complement offsets.
  function automatic logic [31:0] load_value(input logic [4:0] op, input logic [31:0] word, input logic [1:0] va);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (32'(va) * 8)) & 32'hFF;
    h = va[1] ? (word >> 16) : (word & 32'hFFFF);
    if (op == 5'b00001) return (b >= 32'd128) ? b - 32'd256 : b;
    if (op == 5'b00010) return (h >= 32'd32768) ? h - 32'd65536 : h;
    if (op == 5'b01000) return b;
    if (op == 5'b10000) return h;
    return word;
  endfunction

  function automatic ins_t make_ins(input logic [4:0] op, input logic rfm, input logic gr_we,
                                    input logic [4:0] dest, input logic [31:0] result);
    ins_t i;
    i = '0;
    i.load_op      = op;
    i.res_from_mem = rfm;
    i.gr_we        = gr_we;
    i.dest         = dest;
    i.result       = result;
    i.pc           = 32'h1C00_0000 + {result[15:0], 2'b00};
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int   k;
    i = '0;
    i.csr_wvalue = $urandom;
    i.ertn       = ($urandom_range(0, 15) == 0);
    i.syscall    = ($urandom_range(0, 15) == 0);
    i.csr_re     = 1'($urandom_range(0, 1));
    i.csr_we     = 1'($urandom_range(0, 1));
    i.csr_num    = 14'($urandom);
    i.csr_wmask  = $urandom;
    i.gr_we      = 1'($urandom_range(0, 1));
    i.dest       = 5'($urandom);
    i.result     = $urandom;
    i.pc         = $urandom;
    k = $urandom_range(0, 5);
    if (k < 5) begin
      i.load_op      = 5'(1 << k);
      i.res_from_mem = 1'b1;
    end
    return i;
  endfunction

  // One clock of stimulus: drive after the falling edge, check, then advance the model.
  task automatic apply_stimulus(input bit es_valid, input ins_t ins, input bit ws_allowin,
                                input logic [31:0] rdata, input bit flush);
    logic [31:0] word;
    logic [31:0] fin;
    bit          allow;
    @(negedge clk);
    bus_if.es_to_ms_valid  = es_valid;
    bus_if.es_to_ms_bus    = ins;
    bus_if.ws_allowin      = ws_allowin;
    bus_if.data_sram_rdata = rdata;
    bus_if.ms_flush_pipe   = flush;
    #1;
    word  = m_first ? rdata : m_word;
    fin   = m_ins.res_from_mem ? load_value(m_ins.load_op, word, m_ins.result[1:0]) : m_ins.result;
    allow = !m_valid || ws_allowin;
    check_output("allowin", 152'(bus_if.ms_allowin), 152'(allow));
    check_output("to_ws_valid", 152'(bus_if.ms_to_ws_valid), 152'(m_valid && !flush));
    check_output("fwd_valid", 152'(bus_if.ms_fwd_bus[37]), 152'(m_valid && m_ins.gr_we && !flush));
    check_output("ms_ex", 152'(bus_if.ms_ex), 152'(m_valid && (m_ins.syscall || m_ins.ertn)));
    if (m_valid) begin
      check_output("ws_bus", bus_if.ms_to_ws_bus,
                   {m_ins.csr_wvalue, m_ins.ertn, m_ins.syscall, m_ins.csr_re, m_ins.csr_we,
                    m_ins.csr_num, m_ins.csr_wmask, m_ins.gr_we, m_ins.dest, fin, m_ins.pc});
      check_output("fwd_data", 152'({bus_if.ms_fwd_bus[38], bus_if.ms_fwd_bus[36:0]}),
                   152'({m_ins.csr_re, m_ins.dest, fin}));
    end
    obs_final = bus_if.ms_to_ws_bus[63:32];
    obs_fwd   = bus_if.ms_fwd_bus;
    obs_ex    = bus_if.ms_ex;
    @(posedge clk);
    if (m_valid && m_first) m_word = rdata;
    m_first = es_valid && allow;
    if (es_valid && allow) m_ins = ins;
    if (flush) m_valid = 1'b0;
    else if (allow) m_valid = es_valid;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_first = 1'b0;
    m_word  = '0;
    m_ins   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_allowin"}, 152'(bus_if.ms_allowin), 152'(1'b1));
    check_output({tag, "_to_ws_valid"}, 152'(bus_if.ms_to_ws_valid), 152'(1'b0));
    check_output({tag, "_fwd_valid"}, 152'(bus_if.ms_fwd_bus[37]), 152'(1'b0));
    check_output({tag, "_ms_ex"}, 152'(bus_if.ms_ex), 152'(1'b0));
  endtask

  initial begin
    ins_t ins;
    ins_t idle;

    idle = '0;
    bus_if.es_to_ms_valid  = 1'b0;
    bus_if.es_to_ms_bus    = '0;
    bus_if.ws_allowin      = 1'b1;
    bus_if.data_sram_rdata = '0;
    bus_if.ms_flush_pipe   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check_output("reset_fwd_bus", 152'(bus_if.ms_fwd_bus), 152'(0));
    reset = 1'b0;

    // ld.w straight through
    ins = make_ins(5'b00100, 1'b1, 1'b1, 5'd3, 32'h1000);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'h8765_4321, 1'b0);
    check_output("ldw_value", 152'(obs_final), 152'(32'h8765_4321));
    check_output("ldw_fwd_valid", 152'(obs_fwd[37]), 152'(1'b1));

    // byte and half lanes at vaddr 2
    ins = make_ins(5'b00001, 1'b1, 1'b1, 5'd4, 32'h1002);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'h0080_0000, 1'b0);
    check_output("ldb_sext", 152'(obs_final), 152'(32'hFFFF_FF80));
    ins = make_ins(5'b01000, 1'b1, 1'b1, 5'd4, 32'h1002);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'h0080_0000, 1'b0);
    check_output("ldbu_zext", 152'(obs_final), 152'(32'h0000_0080));
    ins = make_ins(5'b00010, 1'b1, 1'b1, 5'd4, 32'h1002);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'h8001_1234, 1'b0);
    check_output("ldh_sext", 152'(obs_final), 152'(32'hFFFF_8001));

    // stalled load keeps first-cycle data, then a later load sees fresh data
    ins = make_ins(5'b00100, 1'b1, 1'b1, 5'd6, 32'h2000);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b0, 32'h1111_2222, 1'b0);
    apply_stimulus(1'b0, idle, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check_output("stall_hold1", 152'(obs_final), 152'(32'h1111_2222));
    apply_stimulus(1'b0, idle, 1'b0, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check_output("stall_handoff", 152'(obs_final), 152'(32'h1111_2222));
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'h3333_4444, 1'b0);
    check_output("after_hold", 152'(obs_final), 152'(32'h3333_4444));

    // ALU result forwarding, with and without csr_re
    ins = make_ins(5'b00000, 1'b0, 1'b1, 5'd5, 32'h55);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'hCAFE_F00D, 1'b0);
    check_output("fwd_alu", 152'(obs_fwd), 152'({1'b0, 1'b1, 5'd5, 32'h55}));
    ins.csr_re = 1'b1;
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'hCAFE_F00D, 1'b0);
    check_output("fwd_csr_re", 152'(obs_fwd), 152'({1'b1, 1'b1, 5'd5, 32'h55}));

    // syscall raises ms_ex even under stall; flush beats a new instruction
    ins = make_ins(5'b00000, 1'b0, 1'b0, 5'd0, 32'h77);
    ins.syscall = 1'b1;
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b0, 32'h0, 1'b0);
    check_output("syscall_ex", 152'(obs_ex), 152'(1'b1));
    ins = make_ins(5'b00000, 1'b0, 1'b1, 5'd9, 32'h99);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b1);
    apply_stimulus(1'b0, idle, 1'b1, 32'h0, 1'b0);

    // reset in the middle of a stall with held data
    ins = make_ins(5'b00100, 1'b1, 1'b1, 5'd7, 32'h3000);
    apply_stimulus(1'b1, ins, 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b0, 32'hAAAA_5555, 1'b0);
    apply_stimulus(1'b0, idle, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b1, ins, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b0, idle, 1'b1, 32'h1234_5678, 1'b0);
    check_output("post_reset_ldw", 152'(obs_final), 152'(32'h1234_5678));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      apply_stimulus(($urandom_range(0, 9) < 7), rand_ins(), ($urandom_range(0, 9) < 6),
                     $urandom, ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. It sits between exe_stage (upstream) and wb_stage (downstream).
- It registers the exe-to-mem bus and receives the data SRAM read data one cycle after the request that exe_stage issued.
- It sign- or zero-extends load data and produces the final writeback value, the forwarding/blocking bus for decode, and the exception/ertn indication.
- It holds captured read data across writeback stalls so that no SRAM response is lost.

Parameters:
- ES_TO_MS_BUS_WD, 158, width of the incoming exe-to-mem bus.
- MS_TO_WS_BUS_WD, 152, width of the outgoing mem-to-wb bus.
- MS_FWD_BUS_WD, 39, width of the forwarding bus to decode.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ws_allowin  in  1  wb_stage can accept an instruction.
- ms_allowin  out  1  this stage can accept an instruction.
- es_to_ms_valid  in  1  exe_stage offers an instruction.
- es_to_ms_bus  in  158  {csr_wvalue[31:0], ertn, syscall, csr_re, csr_we, csr_num[13:0], csr_wmask[31:0], load_op[4:0], res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0]}.
- ms_to_ws_valid  out  1  instruction offered to wb_stage.
- ms_to_ws_bus  out  152  {csr_wvalue, ertn, syscall, csr_re, csr_we, csr_num, csr_wmask, gr_we, dest, final_result[31:0], pc}.
- ms_fwd_bus  out  39  {csr_re, fwd_valid, dest[4:0], final_result[31:0]}.
- data_sram_rdata  in  32  SRAM read data; valid exactly one cycle after the request.
- ms_ex  out  1  ms_valid & (syscall | ertn); exe_stage uses it to suppress younger stores.
- ms_flush_pipe  in  1  flush from the exception/ertn commit.

Behaviour:
- Reset (async, active-high):
  - ms_valid=0, hold_valid=0, first_cycle=0, bus register=0.
  - Outputs: ms_to_ws_valid=0, ms_allowin=1, fwd_valid=0, ms_ex=0.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid | ws_allowin.
  - ms_to_ws_valid = ms_valid & !ms_flush_pipe.
- Valid update on clk edge:
  - If ms_flush_pipe, ms_valid<=0 (flush wins over a simultaneous es_to_ms_valid).
  - Else if ms_allowin, ms_valid<=es_to_ms_valid.
  - Bus register loads when es_to_ms_valid & ms_allowin.
- first_cycle is set to 1 on every accept and cleared the next cycle. It marks the cycle in which data_sram_rdata belongs to this instruction.
- Read-data hold:
  - If ms_valid & first_cycle & res_from_mem & !ws_allowin: rdata_hold<=data_sram_rdata, hold_valid<=1.
  - hold_valid clears on accept of a new instruction, on flush, or when the held instruction moves to wb.
- Load data selection:
  - mem_word = hold_valid ? rdata_hold : data_sram_rdata.
  - Byte/half lane is chosen by vaddr = result[1:0]:
    - byte = mem_word[8*vaddr +: 8].
    - half = vaddr[1] ? [31:16] : [15:0].
- load_op one-hot encoding:
  - [0] ld.b: sign-extend byte.
  - [1] ld.h: sign-extend half.
  - [2] ld.w: whole word.
  - [3] ld.bu: zero-extend byte.
  - [4] ld.hu: zero-extend half.
  - Unaligned half (vaddr[0]=1) is not checked here; use the lane given by vaddr[1].
- final_result = res_from_mem ? load_result : result.
- Forwarding: fwd_valid = ms_valid & gr_we & !ms_flush_pipe. Data is final_result, so loads forward from this stage.
- Exceptions: ms_ex is asserted while ms_valid, regardless of ws_allowin.
- Back-to-back loads under stall: the second load cannot enter until the first leaves, so there is a single hold register and no overwrite case.

Decomposition:
- Shared header (mycpu.h) holds:
  - The bus width defines.
  - load_op bit indices (LD_B=0, LD_H=1, LD_W=2, LD_BU=3, LD_HU=4).
  - Field offsets of both buses.
- One natural sub-module, load_align: combinational mem_word, vaddr and load_op in, load_result out.
- Valid, hold and first_cycle logic stay in mem_stage.

Test Plan:
- ld.w, result=0x1000, rdata=0x8765_4321, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x8765_4321, fwd_valid=1.
- ld.b at vaddr 2, rdata=0x0080_0000 -> final_result=0xFFFF_FF80. Same with ld.bu -> 0x0000_0080. ld.h at vaddr 2, rdata=0x8001_1234 -> 0xFFFF_8001.
- ld.w accepted, ws_allowin=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after the first cycle -> final_result stays the first-cycle value 0x1111_2222 until handoff, then hold_valid=0.
- ALU op with result=0x55, gr_we=1, dest=5 -> ms_fwd_bus={0,1,5,0x55}. Repeat with csr_re=1 -> bit38=1.
- syscall in stage -> ms_ex=1. Assert ms_flush_pipe together with es_to_ms_valid=1 -> ms_to_ws_valid=0 that cycle and ms_valid=0 next cycle.
- Assert reset mid-stall with hold_valid=1 -> immediately ms_to_ws_valid=0, ms_allowin=1, fwd_valid=0. After release, the first accepted ld.w returns the fresh rdata.
